// File: rtl/int_to_float_conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : int_to_float_conv_pkg
// Description : Shared single-precision FP constants: rounding modes, binary32
//               field widths, exponent bias and converter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package int_to_float_conv_pkg;

  // RISC-V static rounding modes
  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  // binary32 field widths
  localparam int FP_EXP_W  = 8;
  localparam int FP_MANT_W = 23;
  localparam int BIAS      = 127;

  // Exponent of a value whose leading one sits at bit 31 of the magnitude
  localparam logic [FP_EXP_W-1:0] EXP_INIT = 8'(BIAS + 31);

  // Converter state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_NORM  = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/int_to_float_conv_fp_round_inc.sv
`default_nettype none
// ============================================================================
// Module      : fp_round_inc
// Description : Combinational round-increment decision from rounding mode,
//               result sign, LSB, guard and sticky bits.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_round_inc
  import int_to_float_conv_pkg::*;
(
  input  logic [2:0] rm,
  input  logic       sign,
  input  logic       lsb,
  input  logic       g,
  input  logic       s,
  output logic       inc
);

  // Select the increment rule; reserved encodings fall back to RNE
  always_comb begin
    inc = 1'b0;
    case (rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & (g | s);
      RM_RUP:  inc = ~sign & (g | s);
      RM_RMM:  inc = g;
      default: inc = g & (s | lsb);
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/int_to_float_conv.sv
`default_nettype none
// ============================================================================
// Module      : int_to_float_conv
// Description : Multi-cycle 32-bit integer to binary32 converter
//               (FCVT.S.W / FCVT.S.WU) with iterative normalisation and
//               valid/ready handshakes on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module int_to_float_conv
  import int_to_float_conv_pkg::*;
#(
  parameter bit FAST_NORM = 1'b1
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] int_in,
  input  logic        is_unsigned,
  input  logic [2:0]  rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] float_out,
  output logic        flag_nx
);

  logic [1:0]  r_state;
  logic [31:0] r_mag;
  logic [7:0]  r_exp;
  logic        r_sign;
  logic [2:0]  r_rm;
  logic [31:0] r_float;
  logic        r_nx;

  logic        w_accept;
  logic        w_in_sign;
  logic [31:0] w_in_mag;
  logic        w_fast_step;
  logic        w_inc;
  logic [23:0] w_mant_sum;
  logic        w_carry;
  logic [22:0] w_mant_rnd;
  logic [7:0]  w_exp_rnd;

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign float_out = r_float;
  assign flag_nx   = r_nx;

  assign w_accept  = in_valid & in_ready;
  assign w_in_sign = ~is_unsigned & int_in[31];
  // Two's complement negation; 0x80000000 maps onto itself, which is the
  // correct unsigned magnitude of INT_MIN
  assign w_in_mag  = w_in_sign ? (~int_in + 32'd1) : int_in;

  assign w_fast_step = FAST_NORM && (r_mag[31:28] == 4'b0000);

  fp_round_inc u_round_inc (
    .rm   (r_rm),
    .sign (r_sign),
    .lsb  (r_mag[8]),
    .g    (r_mag[7]),
    .s    (|r_mag[6:0]),
    .inc  (w_inc)
  );

  // Mantissa increment; a carry out means the mantissa wrapped to zero and
  // the exponent moves up by one (at most 159, so never overflows)
  assign w_mant_sum = {1'b0, r_mag[30:8]} + {23'd0, w_inc};
  assign w_carry    = w_mant_sum[23];
  assign w_mant_rnd = w_carry ? 23'd0 : w_mant_sum[22:0];
  assign w_exp_rnd  = r_exp + {7'd0, w_carry};

  // Conversion state machine and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_mag   <= 32'd0;
      r_exp   <= 8'd0;
      r_sign  <= 1'b0;
      r_rm    <= 3'd0;
      r_float <= 32'd0;
      r_nx    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_rm   <= rm;
            r_sign <= w_in_sign;
            r_mag  <= w_in_mag;
            r_exp  <= EXP_INIT;
            if (w_in_mag == 32'd0) begin
              r_float <= 32'd0;
              r_nx    <= 1'b0;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_NORM;
            end
          end
        end
        ST_NORM: begin
          if (r_mag[31]) begin
            r_state <= ST_ROUND;
          end else if (w_fast_step) begin
            r_mag <= r_mag << 4;
            r_exp <= r_exp - 8'd4;
          end else begin
            r_mag <= r_mag << 1;
            r_exp <= r_exp - 8'd1;
          end
        end
        ST_ROUND: begin
          r_float <= {r_sign, w_exp_rnd, w_mant_rnd};
          r_nx    <= r_mag[7] | (|r_mag[6:0]);
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_int_to_float_conv.sv
`default_nettype none
// ============================================================================
// Module      : tb_int_to_float_conv
// Description : Self-checking bench for int_to_float_conv; runs a slow
//               (FAST_NORM=0) and a fast (FAST_NORM=1) instance side by side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_int_to_float_conv;
  import int_to_float_conv_pkg::*;

  typedef struct {
    logic [31:0] v;
    logic        uns;
    logic [2:0]  rm;
    logic [31:0] ef;
    logic        enx;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] int_in;
  logic        is_unsigned;
  logic [2:0]  rm;
  logic        out_ready;

  logic        in_ready_s, out_valid_s, nx_s;
  logic        in_ready_f, out_valid_f, nx_f;
  logic [31:0] float_s, float_f;

  int checks;
  int errors;

  int_to_float_conv #(.FAST_NORM(1'b0)) u_dut_slow (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .int_in(int_in), .is_unsigned(is_unsigned), .rm(rm),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .float_out(float_s), .flag_nx(nx_s)
  );

  int_to_float_conv #(.FAST_NORM(1'b1)) u_dut_fast (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_f),
    .int_in(int_in), .is_unsigned(is_unsigned), .rm(rm),
    .out_valid(out_valid_f), .out_ready(out_ready),
    .float_out(float_f), .flag_nx(nx_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: exact integer value, rounded by comparing the discarded
  // remainder against one half ULP
  function automatic void model(input logic [31:0] v, input logic uns, input logic [2:0] r,
                                output logic [31:0] f, output logic nx,
                                output int lat_slow, output int lat_fast);
    logic neg;
    longint unsigned m, trunc, rem, half;
    int p, sh, lz, e;
    logic up;
    neg = !uns && v[31];
    m = neg ? (64'h1_0000_0000 - {32'd0, v}) : {32'd0, v};
    if (m == 0) begin
      f = 32'd0; nx = 1'b0; lat_slow = 1; lat_fast = 1;
      return;
    end
    p = 0;
    for (int i = 0; i < 64; i++) if (((m >> i) & 64'd1) != 0) p = i;
    lz = 31 - p;
    lat_slow = lz + 3;
    lat_fast = lz / 4 + lz % 4 + 3;
    e = 127 + p;
    if (p > 23) begin
      sh = p - 23;
      trunc = m >> sh;
      rem = m - (trunc << sh);
      half = 64'd1 << (sh - 1);
    end else begin
      trunc = m << (23 - p);
      rem = 0;
      half = 1;
    end
    case (r)
      3'd1:    up = 1'b0;
      3'd2:    up = neg && (rem != 0);
      3'd3:    up = !neg && (rem != 0);
      3'd4:    up = (rem != 0) && (rem >= half);
      default: up = (rem > half) || ((rem == half) && trunc[0]);
    endcase
    trunc = trunc + (up ? 64'd1 : 64'd0);
    if (trunc == (64'd1 << 24)) begin
      trunc = 64'd1 << 23;
      e = e + 1;
    end
    f = {neg, 8'(e), trunc[22:0]};
    nx = (rem != 0);
  endfunction

  task automatic send(input logic [31:0] v, input logic uns, input logic [2:0] r, input string nm);
    @(negedge clk);
    chk({nm, " in_ready_slow"}, {31'd0, in_ready_s}, 32'd1);
    chk({nm, " in_ready_fast"}, {31'd0, in_ready_f}, 32'd1);
    int_in = v; is_unsigned = uns; rm = r; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Cycle 1 is the first negedge after the handshake edge
  task automatic wait_both(output int ls, output int lf);
    int cyc;
    ls = -1; lf = -1; cyc = 0;
    while ((ls < 0 || lf < 0) && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (ls < 0 && out_valid_s) ls = cyc;
      if (lf < 0 && out_valid_f) lf = cyc;
    end
  endtask

  task automatic release_out(input string nm);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({nm, " in_ready_after_slow"}, {31'd0, in_ready_s}, 32'd1);
    chk({nm, " in_ready_after_fast"}, {31'd0, in_ready_f}, 32'd1);
    chk({nm, " out_valid_after"}, {30'd0, out_valid_s, out_valid_f}, 32'd0);
  endtask

  task automatic run_conv(input logic [31:0] v, input logic uns, input logic [2:0] r,
                          input logic [31:0] ef, input logic enx, input string nm);
    logic [31:0] mf; logic mnx; int els, elf, ls, lf;
    model(v, uns, r, mf, mnx, els, elf);
    send(v, uns, r, nm);
    wait_both(ls, lf);
    chk({nm, " float_slow"}, float_s, ef);
    chk({nm, " float_fast"}, float_f, ef);
    chk({nm, " nx"}, {30'd0, nx_s, nx_f}, {30'd0, enx, enx});
    chk({nm, " lat_slow"}, 32'(ls), 32'(els));
    chk({nm, " lat_fast"}, 32'(lf), 32'(elf));
    release_out(nm);
  endtask

  initial begin
    vec_t tbl[12];
    logic [31:0] mf, hold_f;
    logic mnx;
    int els, elf, ls, lf;

    tbl[0]  = '{32'h0000_0001, 1'b0, RM_RNE, 32'h3F80_0000, 1'b0};
    tbl[1]  = '{32'hFFFF_FFFF, 1'b0, RM_RNE, 32'hBF80_0000, 1'b0};
    tbl[2]  = '{32'h8000_0000, 1'b0, RM_RNE, 32'hCF00_0000, 1'b0};
    tbl[3]  = '{32'h0000_0000, 1'b0, RM_RNE, 32'h0000_0000, 1'b0};
    tbl[4]  = '{32'h0000_0000, 1'b1, RM_RUP, 32'h0000_0000, 1'b0};
    tbl[5]  = '{32'hFFFF_FFFF, 1'b1, RM_RNE, 32'h4F80_0000, 1'b1};
    tbl[6]  = '{32'hFFFF_FFFF, 1'b1, RM_RTZ, 32'h4F7F_FFFF, 1'b1};
    tbl[7]  = '{32'h0100_0001, 1'b0, RM_RNE, 32'h4B80_0000, 1'b1};
    tbl[8]  = '{32'h0100_0001, 1'b0, RM_RUP, 32'h4B80_0001, 1'b1};
    tbl[9]  = '{32'h0100_0001, 1'b0, RM_RMM, 32'h4B80_0001, 1'b1};
    tbl[10] = '{32'hFEFF_FFFF, 1'b0, RM_RDN, 32'hCB80_0001, 1'b1};
    tbl[11] = '{32'h0100_0001, 1'b0, 3'b111, 32'h4B80_0000, 1'b1};

    checks = 0; errors = 0;
    rst_n = 1'b0; in_valid = 1'b0; int_in = 32'd0; is_unsigned = 1'b0;
    rm = 3'd0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset in_ready", {30'd0, in_ready_s, in_ready_f}, 32'd3);
    chk("reset out_valid", {30'd0, out_valid_s, out_valid_f}, 32'd0);
    chk("reset float", float_s | float_f, 32'd0);
    chk("reset nx", {30'd0, nx_s, nx_f}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      run_conv(tbl[i].v, tbl[i].uns, tbl[i].rm, tbl[i].ef, tbl[i].enx, $sformatf("vec%0d", i));

    // Backpressure: result held in DONE, stray in_valid ignored
    model(32'h0012_3457, 1'b1, RM_RUP, mf, mnx, els, elf);
    send(32'h0012_3457, 1'b1, RM_RUP, "bp");
    wait_both(ls, lf);
    hold_f = float_s;
    chk("bp float", hold_f, mf);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin int_in = 32'h1234_5678; in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(negedge clk);
      chk("bp out_valid", {30'd0, out_valid_s, out_valid_f}, 32'd3);
      chk("bp float_hold", float_s, hold_f);
      chk("bp float_fast_hold", float_f, hold_f);
      chk("bp in_ready", {30'd0, in_ready_s, in_ready_f}, 32'd0);
    end
    in_valid = 1'b0;
    release_out("bp");

    // Asynchronous reset in the middle of normalisation
    send(32'h0000_0001, 1'b0, RM_RNE, "rst");
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst out_valid", {30'd0, out_valid_s, out_valid_f}, 32'd0);
    chk("rst in_ready", {30'd0, in_ready_s, in_ready_f}, 32'd3);
    @(negedge clk);
    rst_n = 1'b1;
    run_conv(32'h0100_0001, 1'b0, RM_RUP, 32'h4B80_0001, 1'b1, "post_rst");

    // Randomised operands against the reference model
    for (int i = 0; i < 60; i++) begin
      logic [31:0] v; logic u; logic [2:0] r;
      v = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) v = -v;
      u = 1'($urandom_range(0, 1));
      r = 3'($urandom_range(0, 7));
      model(v, u, r, mf, mnx, els, elf);
      run_conv(v, u, r, mf, mnx, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
